// File: rtl/gpu_loader.sv
// Copies SIZE words from a synchronous-read source RAM starting at src_base into
// gpu_mem addresses 0..SIZE-1, one read per cycle unless the source RAM holds us off.
`ifndef RECT_COUNT
`define RECT_COUNT 4
`endif
`ifndef RECT_COUNT_WIDTH
`define RECT_COUNT_WIDTH 2
`endif

module gpu_loader #(
  parameter int ADDR_WIDTH = `RECT_COUNT_WIDTH,
  parameter int SIZE       = `RECT_COUNT,
  parameter int DATA_WIDTH = 16,
  parameter int SRC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SRC_WIDTH-1:0]  src_base,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_re,
  output logic [SRC_WIDTH-1:0]  ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] mem_din_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);

  state_t                state_q;
  logic [SRC_WIDTH-1:0]  base_q;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  rd_valid;
  logic                  last_wr;

  // Protocol: start is a one-cycle request honoured only in IDLE; hold=1 stalls the
  // read side for that cycle, while a read already issued is still written next cycle.
  assign ram_re       = (state_q == COPY) && !hold;
  assign ram_addr     = base_q + SRC_WIDTH'(rd_idx);
  assign we           = rd_valid;
  assign mem_din      = ram_dout;
  assign mem_din_addr = wr_idx;
  assign last_wr      = rd_valid && (wr_idx == LAST);
  assign done         = last_wr;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      rd_idx   <= '0;
      wr_idx   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= ram_re;
      if (rd_valid) wr_idx <= wr_idx + 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q  <= src_base;
            rd_idx  <= '0;
            wr_idx  <= '0;
            state_q <= COPY;
          end
        end
        COPY: begin
          if (!hold) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_idx == LAST) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_wr) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_loader.sv
// Directed table-driven bench for gpu_loader: per-cycle vectors, a gpu_mem write
// scoreboard, and hand-written reset sequences.
module tb_gpu_loader;
  localparam int AW = 2;
  localparam int DW = 16;
  localparam int SW = 16;
  localparam int SZ = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [SW-1:0] src_base = '0;
  logic          busy, done, ram_re, we;
  logic [SW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] mem_din;
  logic [AW-1:0] mem_din_addr;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_w;

  // clock / reset
  always #5 clk = ~clk;

  gpu_loader #(.ADDR_WIDTH(AW), .SIZE(SZ), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .hold(hold),
    .busy(busy), .done(done), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .we(we), .mem_din_addr(mem_din_addr), .mem_din(mem_din),
    .dbg_state(dbg_state)
  );

  // source RAM contents as a fixed function of address
  function automatic logic [DW-1:0] rd(input logic [SW-1:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  always @(posedge clk) if (ram_re) ram_dout <= rd(ram_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every gpu_mem write must match the head of the expected queue
  always begin
    @(negedge clk);
    #3;
    if (done) done_cnt++;
    if (we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected none", {mem_din_addr, mem_din});
      end else begin
        exp_w = exp_q.pop_front();
        chk("write", {14'd0, mem_din_addr, mem_din}, {14'd0, exp_w});
      end
    end
  end

  typedef struct {
    logic          start;
    logic          hold;
    logic [SW-1:0] base;
    logic [1:0]    st;
    logic          busy;
    logic          re;
    logic [SW-1:0] addr;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          done;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic s, input logic h, input logic [SW-1:0] b,
                              input logic [1:0] st, input logic bz, input logic re,
                              input logic [SW-1:0] a, input logic w, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic d);
    vec_t v;
    v.start = s; v.hold = h; v.base = b; v.st = st; v.busy = bz; v.re = re;
    v.addr = a; v.we = w; v.waddr = wa; v.wdata = wd; v.done = d;
    vt.push_back(v);
  endfunction

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      start    = vt[i].start;
      hold     = vt[i].hold;
      src_base = vt[i].base;
      #2;
      chk($sformatf("v%0d.state", i), {30'd0, dbg_state}, {30'd0, vt[i].st});
      chk($sformatf("v%0d.busy", i), {31'd0, busy}, {31'd0, vt[i].busy});
      chk($sformatf("v%0d.ram_re", i), {31'd0, ram_re}, {31'd0, vt[i].re});
      if (vt[i].re) chk($sformatf("v%0d.ram_addr", i), {16'd0, ram_addr}, {16'd0, vt[i].addr});
      chk($sformatf("v%0d.we", i), {31'd0, we}, {31'd0, vt[i].we});
      if (vt[i].we) begin
        chk($sformatf("v%0d.waddr", i), {30'd0, mem_din_addr}, {30'd0, vt[i].waddr});
        chk($sformatf("v%0d.wdata", i), {16'd0, mem_din}, {16'd0, vt[i].wdata});
        exp_q.push_back({vt[i].waddr, vt[i].wdata});
      end
      chk($sformatf("v%0d.done", i), {31'd0, done}, {31'd0, vt[i].done});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".state"}, {30'd0, dbg_state}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
    chk({tag, ".ram_re"}, {31'd0, ram_re}, 32'd0);
    chk({tag, ".we"}, {31'd0, we}, 32'd0);
    chk({tag, ".waddr"}, {30'd0, mem_din_addr}, 32'd0);
    chk({tag, ".ram_addr"}, {16'd0, ram_addr}, 32'd0);
  endtask

  initial begin
    logic [SW-1:0] b;
    logic [SW-1:0] f;
    b = 16'h0010;
    f = 16'hFFFE;
    // rows 0-6: plain transfer from 0x0010
    add(1, 0, b, 0, 0, 0, 0,        0, 0, 0,            0);
    add(0, 0, b, 1, 1, 1, 16'h0010, 0, 0, 0,            0);
    add(0, 0, b, 1, 1, 1, 16'h0011, 1, 0, rd(16'h0010), 0);
    add(0, 0, b, 1, 1, 1, 16'h0012, 1, 1, rd(16'h0011), 0);
    add(0, 0, b, 1, 1, 1, 16'h0013, 1, 2, rd(16'h0012), 0);
    add(0, 0, b, 2, 1, 0, 0,        1, 3, rd(16'h0013), 1);
    add(0, 0, b, 0, 0, 0, 0,        0, 0, 0,            0);
    // rows 7-14: hold on cycle 2 delays the tail by one cycle
    add(1, 0, b, 0, 0, 0, 0,        0, 0, 0,            0);
    add(0, 0, b, 1, 1, 1, 16'h0010, 0, 0, 0,            0);
    add(0, 1, b, 1, 1, 0, 0,        1, 0, rd(16'h0010), 0);
    add(0, 0, b, 1, 1, 1, 16'h0011, 0, 0, 0,            0);
    add(0, 0, b, 1, 1, 1, 16'h0012, 1, 1, rd(16'h0011), 0);
    add(0, 0, b, 1, 1, 1, 16'h0013, 1, 2, rd(16'h0012), 0);
    add(0, 0, b, 2, 1, 0, 0,        1, 3, rd(16'h0013), 1);
    add(0, 0, b, 0, 0, 0, 0,        0, 0, 0,            0);
    // rows 15-21: source address wraps past 0xFFFF
    add(1, 0, f, 0, 0, 0, 0,        0, 0, 0,            0);
    add(0, 0, f, 1, 1, 1, 16'hFFFE, 0, 0, 0,            0);
    add(0, 0, f, 1, 1, 1, 16'hFFFF, 1, 0, rd(16'hFFFE), 0);
    add(0, 0, f, 1, 1, 1, 16'h0000, 1, 1, rd(16'hFFFF), 0);
    add(0, 0, f, 1, 1, 1, 16'h0001, 1, 2, rd(16'h0000), 0);
    add(0, 0, f, 2, 1, 0, 0,        1, 3, rd(16'h0001), 1);
    add(0, 0, f, 0, 0, 0, 0,        0, 0, 0,            0);
    // rows 22-28: start re-pulsed (with a new base) on cycles 2 and 5 is ignored
    add(1, 0, b,        0, 0, 0, 0,        0, 0, 0,            0);
    add(0, 0, b,        1, 1, 1, 16'h0010, 0, 0, 0,            0);
    add(1, 0, 16'h0200, 1, 1, 1, 16'h0011, 1, 0, rd(16'h0010), 0);
    add(0, 0, b,        1, 1, 1, 16'h0012, 1, 1, rd(16'h0011), 0);
    add(0, 0, b,        1, 1, 1, 16'h0013, 1, 2, rd(16'h0012), 0);
    add(1, 0, 16'h0200, 2, 1, 0, 0,        1, 3, rd(16'h0013), 1);
    add(0, 0, b,        0, 0, 0, 0,        0, 0, 0,            0);

    // reset state
    #2;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    apply(0, 28);
    chk("done_pulses", done_cnt, 32'd4);
    chk("write_count", wr_cnt, 32'd16);

    // abort on cycle 3 of a transfer: outputs drop without a clock edge
    apply(0, 2);
    @(negedge clk);
    start = 1'b0;
    hold  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(negedge clk);
    chk("abort_writes", wr_cnt, 32'd17);
    chk("abort_done", done_cnt, 32'd4);

    // start honoured on the first edge after reset release
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(0, 6);
    repeat (2) @(negedge clk);
    chk("final_done_pulses", done_cnt, 32'd5);
    chk("final_write_count", wr_cnt, 32'd21);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpu_loader.md
GPU_LOADER -- requirements
Module: gpu_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default `RECT_COUNT_WIDTH, gpu_mem write-address width.
REQ-002 Parameter SIZE, default `RECT_COUNT, number of words copied per transfer.
REQ-003 Parameter DATA_WIDTH, default 16, word width.
REQ-004 Parameter SRC_WIDTH, default 16, source RAM address width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin a transfer.
REQ-008 src_base  input  SRC_WIDTH  source start address, sampled with start.
REQ-009 hold  input  1  source RAM busy; no new read is issued while high.
REQ-010 busy  output  1  high while a transfer is in progress.
REQ-011 done  output  1  one-cycle pulse on completion of the last write.
REQ-012 ram_re  output  1  source RAM read enable.
REQ-013 ram_addr  output  SRC_WIDTH  source RAM read address.
REQ-014 ram_dout  input  DATA_WIDTH  source RAM data, valid the cycle after ram_re (synchronous read).
REQ-015 we  output  1  gpu_mem write enable.
REQ-016 mem_din_addr  output  ADDR_WIDTH  gpu_mem write address.
REQ-017 mem_din  output  DATA_WIDTH  gpu_mem write data.

Function
REQ-018 The block SHALL implement states IDLE, COPY, DRAIN; busy=1 in COPY and DRAIN only.
REQ-019 In IDLE, start=1 SHALL latch src_base, clear rd_idx and wr_idx, and enter COPY next cycle.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 In COPY with hold=0, ram_re SHALL be 1, ram_addr SHALL equal (base + rd_idx) mod 2^SRC_WIDTH, and rd_idx SHALL increment.
REQ-022 In COPY with hold=1, ram_re SHALL be 0 and rd_idx SHALL hold.
REQ-023 A registered flag SHALL record ram_re; in the following cycle we SHALL be 1, mem_din SHALL equal ram_dout, and mem_din_addr SHALL equal wr_idx.
REQ-024 wr_idx SHALL increment on every cycle with we=1, independent of hold.
REQ-025 Issuing the read for index SIZE-1 SHALL move COPY to DRAIN.
REQ-026 In DRAIN, ram_re SHALL be 0; after the write of index SIZE-1 the state SHALL return to IDLE with done=1 for exactly that cycle.
REQ-027 done SHALL be asserted in the same cycle as the final we=1, and busy SHALL be 0 from the next cycle.
REQ-028 With hold=0 throughout, a transfer SHALL take SIZE+1 cycles from the first COPY cycle to the final write, inclusive.
REQ-029 Exactly SIZE writes SHALL occur per transfer, to addresses 0..SIZE-1 in ascending order, with no duplicates or gaps.
REQ-030 ram_addr wrap-around past 2^SRC_WIDTH-1 SHALL be permitted and SHALL be silent.
REQ-031 we, ram_re and done SHALL be 0 in IDLE except the final write cycle (REQ-026).
REQ-032 start coinciding with the done cycle SHALL be ignored; a new transfer is accepted only in IDLE.

Reset
REQ-033 rst_n=0 SHALL immediately, without a clock edge, force IDLE, busy=0, done=0, ram_re=0, we=0, mem_din_addr=0, ram_addr=0, and clear both counters and the read-valid flag.
REQ-034 Reset mid-transfer SHALL abort the transfer, with no further writes; already-written gpu_mem entries remain unchanged.
REQ-035 After rst_n deasserts, the block SHALL accept start on the first clock edge.

Verification
REQ-036 SIZE=4, src_base=0x0010, hold=0, RAM[0x10..0x13]=A,B,C,D -> ram_re on cycles 1-4, writes (0,A),(1,B),(2,C),(3,D) on cycles 2-5, done on cycle 5, busy low on cycle 6.
REQ-037 Same as REQ-036 with hold=1 on cycle 2 only -> addresses 0x10,-,0x11,0x12,0x13; writes remain in order 0..3 with correct data; done one cycle later (cycle 6).
REQ-038 src_base=0xFFFE, SIZE=4 -> ram_addr sequence FFFE, FFFF, 0000, 0001; 4 writes.
REQ-039 start pulsed again on cycles 2 and 5 during a transfer -> ignored; exactly 4 writes and one done pulse.
REQ-040 rst_n low on cycle 3 of a transfer -> we and busy drop to 0 asynchronously, no further writes, and a new start after reset yields a complete correct transfer.
